// File: rtl/dispatch_unit_if.sv
// Dispatch unit bus bundle: instruction-queue handshake, resource-free
// inputs, flush control and the registered dispatch payload.
//   slave  : dispatch_unit side (consumes queue, produces dispatch).
//   master : environment side (drives queue/resources, observes dispatch).
interface dispatch_unit_if #(
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned TAG_WIDTH   = 4
);
    logic                   iq_valid;
    logic [INSTR_WIDTH-1:0] iq_instr;
    logic                   iq_stall;
    logic                   alu_rs_free;
    logic                   lsu_rs_free;
    logic                   rob_free;
    logic                   flush;
    logic [TAG_WIDTH-1:0]   flush_tag;
    logic                   alu_dispatch;
    logic                   lsu_dispatch;
    logic [INSTR_WIDTH-1:0] disp_instr;
    logic [TAG_WIDTH-1:0]   disp_tag;
    logic [4:0]             disp_rs;
    logic [4:0]             disp_rt;
    logic [4:0]             disp_rd;
    logic [15:0]            disp_imm;

    modport slave (
        input  iq_valid, iq_instr, alu_rs_free, lsu_rs_free, rob_free,
               flush, flush_tag,
        output iq_stall, alu_dispatch, lsu_dispatch, disp_instr, disp_tag,
               disp_rs, disp_rt, disp_rd, disp_imm
    );

    modport master (
        output iq_valid, iq_instr, alu_rs_free, lsu_rs_free, rob_free,
               flush, flush_tag,
        input  iq_stall, alu_dispatch, lsu_dispatch, disp_instr, disp_tag,
               disp_rs, disp_rt, disp_rd, disp_imm
    );
endinterface

// File: rtl/dispatch_unit.sv
// Dispatch unit: consumer end of the instruction queue. Holds one instruction,
// classifies it as ALU or LSU, allocates a ROB tag and emits a one-cycle
// registered dispatch strobe. Back-pressures the queue via iq_stall.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : dispatch_unit_if.slave (queue handshake, resource frees,
//             flush/flush_tag, dispatch strobes and payload fields)
module dispatch_unit #(
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned TAG_WIDTH   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    dispatch_unit_if.slave   bus
);

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} state_e;

    state_e                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] held_q, held_d;
    logic [INSTR_WIDTH-1:0] disp_instr_q, disp_instr_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [TAG_WIDTH-1:0]   disp_tag_q, disp_tag_d;
    logic                   alu_dispatch_q, alu_dispatch_d;
    logic                   lsu_dispatch_q, lsu_dispatch_d;

    logic held_is_lsu_c;
    logic go_c;
    logic stall_c;
    logic accept_c;
    logic in_nop_c;

    // Handshake: go when the held instruction's RS and the ROB both have room.
    always_comb begin
        held_is_lsu_c = (held_q[31:26] == OP_LW) || (held_q[31:26] == OP_SW);
        go_c          = (state_q == HELD) && bus.rob_free &&
                        (held_is_lsu_c ? bus.lsu_rs_free : bus.alu_rs_free);
        stall_c       = bus.flush || ((state_q == HELD) && !go_c);
        accept_c      = bus.iq_valid && !stall_c;
        in_nop_c      = (bus.iq_instr == '0);
    end

    // Next-state and registered-output logic; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        held_d         = held_q;
        tag_d          = tag_q;
        disp_instr_d   = disp_instr_q;
        disp_tag_d     = disp_tag_q;
        alu_dispatch_d = 1'b0;
        lsu_dispatch_d = 1'b0;

        if (bus.flush) begin
            state_d = EMPTY;
            tag_d   = bus.flush_tag;
        end else begin
            if (go_c) begin
                alu_dispatch_d = !held_is_lsu_c;
                lsu_dispatch_d = held_is_lsu_c;
                disp_instr_d   = held_q;
                disp_tag_d     = tag_q;
                tag_d          = tag_q + TAG_WIDTH'(1);
                state_d        = EMPTY;
            end
            // NOPs are consumed without occupying the holding register.
            if (accept_c && !in_nop_c) begin
                held_d  = bus.iq_instr;
                state_d = HELD;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= EMPTY;
            held_q         <= '0;
            tag_q          <= '0;
            disp_instr_q   <= '0;
            disp_tag_q     <= '0;
            alu_dispatch_q <= 1'b0;
            lsu_dispatch_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            held_q         <= held_d;
            tag_q          <= tag_d;
            disp_instr_q   <= disp_instr_d;
            disp_tag_q     <= disp_tag_d;
            alu_dispatch_q <= alu_dispatch_d;
            lsu_dispatch_q <= lsu_dispatch_d;
        end
    end

    assign bus.iq_stall     = stall_c;
    assign bus.alu_dispatch = alu_dispatch_q;
    assign bus.lsu_dispatch = lsu_dispatch_q;
    assign bus.disp_instr   = disp_instr_q;
    assign bus.disp_tag     = disp_tag_q;
    assign bus.disp_rs      = disp_instr_q[25:21];
    assign bus.disp_rt      = disp_instr_q[20:16];
    assign bus.disp_rd      = disp_instr_q[15:11];
    assign bus.disp_imm     = disp_instr_q[15:0];

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed self-checking bench for dispatch_unit.
module tb_dispatch_unit;

    localparam int unsigned IW = 32;
    localparam int unsigned TW = 4;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    dispatch_unit_if #(.INSTR_WIDTH(IW), .TAG_WIDTH(TW)) bus ();

    dispatch_unit #(.INSTR_WIDTH(IW), .TAG_WIDTH(TW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_add(input logic [4:0] rd);
        return {6'h00, 5'd1, 5'd2, rd, 5'd0, 6'h20};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n         = 1'b0;
        bus.iq_valid    = 1'b0;
        bus.iq_instr    = '0;
        bus.alu_rs_free = 1'b1;
        bus.lsu_rs_free = 1'b1;
        bus.rob_free    = 1'b1;
        bus.flush       = 1'b0;
        bus.flush_tag   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch, bus.iq_stall} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=000",
                     {bus.alu_dispatch, bus.lsu_dispatch, bus.iq_stall});
        end
        checks++;
        if ({bus.disp_instr, bus.disp_tag} !== 36'h0) begin
            failures++;
            $display("FAIL reset_fields got=%h exp=0", {bus.disp_instr, bus.disp_tag});
        end
    endtask

    task automatic test_single_lw();
        apply_reset();
        bus.iq_valid = 1'b1;
        bus.iq_instr = 32'h8C430004;
        #1;
        checks++;
        if (bus.iq_stall !== 1'b0) begin
            failures++;
            $display("FAIL lw_stall_empty got=%b exp=0", bus.iq_stall);
        end
        step();
        bus.iq_valid = 1'b0;
        bus.iq_instr = '0;
        #1;
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch, bus.iq_stall} !== 3'b000) begin
            failures++;
            $display("FAIL lw_latency got=%b exp=000",
                     {bus.alu_dispatch, bus.lsu_dispatch, bus.iq_stall});
        end
        step();
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch} !== 2'b01 || bus.disp_tag !== 4'd0 ||
            bus.disp_rs !== 5'd2 || bus.disp_rt !== 5'd3 || bus.disp_imm !== 16'h0004 ||
            bus.disp_instr !== 32'h8C430004) begin
            failures++;
            $display("FAIL lw_dispatch got alu=%b lsu=%b tag=%0d rs=%0d rt=%0d imm=%h exp alu=0 lsu=1 tag=0 rs=2 rt=3 imm=0004",
                     bus.alu_dispatch, bus.lsu_dispatch, bus.disp_tag, bus.disp_rs,
                     bus.disp_rt, bus.disp_imm);
        end
        step();
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch} !== 2'b00 || bus.disp_instr !== 32'h8C430004) begin
            failures++;
            $display("FAIL lw_one_cycle got strobes=%b instr=%h exp strobes=00 instr=8c430004",
                     {bus.alu_dispatch, bus.lsu_dispatch}, bus.disp_instr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        int          bad;
        apply_reset();
        prev = '0;
        bad  = 0;
        for (int i = 0; i <= 20; i++) begin
            bus.iq_valid = (i < 20);
            bus.iq_instr = (i < 20) ? mk_add(5'(i + 1)) : 32'h0;
            #1;
            checks++;
            if (bus.iq_stall !== 1'b0) begin
                failures++;
                $display("FAIL b2b_stall i=%0d got=%b exp=0", i, bus.iq_stall);
            end
            step();
            if (i >= 1) begin
                checks++;
                if ({bus.alu_dispatch, bus.lsu_dispatch} !== 2'b10 ||
                    bus.disp_instr !== prev || bus.disp_tag !== 4'((i - 1) % 16)) begin
                    failures++;
                    bad++;
                    $display("FAIL b2b_dispatch i=%0d got strobes=%b instr=%h tag=%0d exp strobes=10 instr=%h tag=%0d",
                             i, {bus.alu_dispatch, bus.lsu_dispatch}, bus.disp_instr,
                             bus.disp_tag, prev, (i - 1) % 16);
                end
            end
            prev = mk_add(5'(i + 1));
        end
        step();
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_drain got=%b exp=00", {bus.alu_dispatch, bus.lsu_dispatch});
        end
    endtask

    task automatic test_lsu_backpressure();
        apply_reset();
        bus.lsu_rs_free = 1'b0;
        bus.iq_valid    = 1'b1;
        bus.iq_instr    = 32'hAC450008;
        step();
        bus.iq_instr = mk_add(5'd7);
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({bus.iq_stall, bus.alu_dispatch, bus.lsu_dispatch} !== 3'b100) begin
                failures++;
                $display("FAIL bp_hold c=%0d got stall/alu/lsu=%b exp=100", c,
                         {bus.iq_stall, bus.alu_dispatch, bus.lsu_dispatch});
            end
            step();
        end
        bus.lsu_rs_free = 1'b1;
        #1;
        checks++;
        if (bus.iq_stall !== 1'b0) begin
            failures++;
            $display("FAIL bp_release_stall got=%b exp=0", bus.iq_stall);
        end
        step();
        bus.iq_valid = 1'b0;
        bus.iq_instr = '0;
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch} !== 2'b01 ||
            bus.disp_instr !== 32'hAC450008 || bus.disp_tag !== 4'd0) begin
            failures++;
            $display("FAIL bp_sw_first got strobes=%b instr=%h tag=%0d exp strobes=01 instr=ac450008 tag=0",
                     {bus.alu_dispatch, bus.lsu_dispatch}, bus.disp_instr, bus.disp_tag);
        end
        step();
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch} !== 2'b10 ||
            bus.disp_instr !== mk_add(5'd7) || bus.disp_tag !== 4'd1) begin
            failures++;
            $display("FAIL bp_add_next got strobes=%b instr=%h tag=%0d exp strobes=10 instr=%h tag=1",
                     {bus.alu_dispatch, bus.lsu_dispatch}, bus.disp_instr, bus.disp_tag,
                     mk_add(5'd7));
        end
    endtask

    task automatic test_nop();
        apply_reset();
        bus.iq_valid = 1'b1;
        bus.iq_instr = mk_add(5'd10);
        step();
        bus.iq_instr = 32'h0;
        #1;
        checks++;
        if (bus.iq_stall !== 1'b0) begin
            failures++;
            $display("FAIL nop_stall got=%b exp=0", bus.iq_stall);
        end
        step();
        bus.iq_instr = mk_add(5'd11);
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch} !== 2'b10 || bus.disp_tag !== 4'd0 ||
            bus.disp_instr !== mk_add(5'd10)) begin
            failures++;
            $display("FAIL nop_first got strobes=%b tag=%0d instr=%h exp strobes=10 tag=0",
                     {bus.alu_dispatch, bus.lsu_dispatch}, bus.disp_tag, bus.disp_instr);
        end
        step();
        bus.iq_valid = 1'b0;
        bus.iq_instr = '0;
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch} !== 2'b00) begin
            failures++;
            $display("FAIL nop_no_dispatch got=%b exp=00", {bus.alu_dispatch, bus.lsu_dispatch});
        end
        step();
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch} !== 2'b10 || bus.disp_tag !== 4'd1 ||
            bus.disp_instr !== mk_add(5'd11)) begin
            failures++;
            $display("FAIL nop_second got strobes=%b tag=%0d instr=%h exp strobes=10 tag=1",
                     {bus.alu_dispatch, bus.lsu_dispatch}, bus.disp_tag, bus.disp_instr);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        bus.iq_valid = 1'b1;
        bus.iq_instr = mk_add(5'd20);
        step();
        bus.iq_instr  = mk_add(5'd21);
        bus.flush     = 1'b1;
        bus.flush_tag = 4'd9;
        #1;
        checks++;
        if (bus.iq_stall !== 1'b1) begin
            failures++;
            $display("FAIL flush_stall got=%b exp=1", bus.iq_stall);
        end
        step();
        bus.flush    = 1'b0;
        bus.iq_valid = 1'b0;
        bus.iq_instr = '0;
        #1;
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch, bus.iq_stall} !== 3'b000) begin
            failures++;
            $display("FAIL flush_no_strobe got alu/lsu/stall=%b exp=000",
                     {bus.alu_dispatch, bus.lsu_dispatch, bus.iq_stall});
        end
        step();
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch} !== 2'b00) begin
            failures++;
            $display("FAIL flush_dropped got=%b exp=00", {bus.alu_dispatch, bus.lsu_dispatch});
        end
        bus.iq_valid = 1'b1;
        bus.iq_instr = mk_add(5'd22);
        step();
        bus.iq_valid = 1'b0;
        bus.iq_instr = '0;
        step();
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch} !== 2'b10 || bus.disp_tag !== 4'd9 ||
            bus.disp_instr !== mk_add(5'd22)) begin
            failures++;
            $display("FAIL flush_tag_load got strobes=%b tag=%0d instr=%h exp strobes=10 tag=9",
                     {bus.alu_dispatch, bus.lsu_dispatch}, bus.disp_tag, bus.disp_instr);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.iq_valid = 1'b1;
        bus.iq_instr = mk_add(5'd1);
        step();
        bus.iq_instr = mk_add(5'd2);
        step();
        bus.iq_valid = 1'b0;
        bus.iq_instr = '0;
        checks++;
        if (bus.alu_dispatch !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre got=%b exp=1", bus.alu_dispatch);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch, bus.iq_stall} !== 3'b000 ||
            bus.disp_instr !== 32'h0 || bus.disp_tag !== 4'd0) begin
            failures++;
            $display("FAIL areset_clear got strobes/stall=%b instr=%h tag=%0d exp 000 0 0",
                     {bus.alu_dispatch, bus.lsu_dispatch, bus.iq_stall},
                     bus.disp_instr, bus.disp_tag);
        end
        step();
        reset_n = 1'b1;
        #1;
        bus.iq_valid = 1'b1;
        bus.iq_instr = mk_add(5'd3);
        step();
        bus.iq_valid = 1'b0;
        bus.iq_instr = '0;
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch} !== 2'b00) begin
            failures++;
            $display("FAIL areset_lost got=%b exp=00", {bus.alu_dispatch, bus.lsu_dispatch});
        end
        step();
        checks++;
        if ({bus.alu_dispatch, bus.lsu_dispatch} !== 2'b10 || bus.disp_tag !== 4'd0 ||
            bus.disp_instr !== mk_add(5'd3)) begin
            failures++;
            $display("FAIL areset_tag got strobes=%b tag=%0d instr=%h exp strobes=10 tag=0",
                     {bus.alu_dispatch, bus.lsu_dispatch}, bus.disp_tag, bus.disp_instr);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_lw();
        test_back_to_back();
        test_lsu_backpressure();
        test_nop();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dispatch_unit.md
Name: dispatch_unit

Overview:
- Consumer end of the instruction queue in the out-of-order core.
- Takes instructions offered by the queue and holds one in a single-entry holding register.
- Decodes the opcode class, allocates a ROB tag, and issues a one-cycle dispatch strobe to the ALU or LSU reservation station.
- Drives the queue's stall input as back-pressure when the target RS or the ROB has no free entry.

Parameters:
- INSTR_WIDTH, 32, instruction bit width; opcode is bits [31:26].
- TAG_WIDTH, 4, ROB tag width; tags wrap modulo 2^TAG_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- iq_valid  input  1  queue offers iq_instr this cycle.
- iq_instr  input  INSTR_WIDTH  offered instruction.
- iq_stall  output  1  combinational; high = instruction not accepted, queue must hold it.
- alu_rs_free  input  1  ALU RS has at least one free slot.
- lsu_rs_free  input  1  LSU RS has at least one free slot.
- rob_free  input  1  ROB has at least one free entry.
- flush  input  1  branch mispredict or exception; discard held instruction.
- flush_tag  input  TAG_WIDTH  tag counter restart value on flush.
- alu_dispatch  output  1  registered one-cycle strobe to ALU RS.
- lsu_dispatch  output  1  registered one-cycle strobe to LSU RS.
- disp_instr  output  INSTR_WIDTH  dispatched instruction.
- disp_tag  output  TAG_WIDTH  allocated ROB tag.
- disp_rs, disp_rt, disp_rd  output  5 each  bits [25:21], [20:16], [15:11].
- disp_imm  output  16  bits [15:0].

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to EMPTY; tag counter goes to 0.
  - All registered outputs clear to 0.
  - iq_stall reads 0, since state is EMPTY and flush is assumed low.
- States:
  - EMPTY: no instruction held.
  - HELD: holding register contains one instruction.
- Opcode classes:
  - LSU class: opcode 6'h23 (lw) or 6'h2B (sw).
  - ALU class: every other opcode, including branches.
  - NOP: instruction == 0. Accepted but never dispatched and never allocates a tag; the state stays or returns to EMPTY.
- go (combinational) = state==HELD and rob_free and the class-matched RS free (alu_rs_free or lsu_rs_free).
- iq_stall = flush OR (state==HELD AND NOT go).
- Accept: iq_valid and not iq_stall at a rising edge. The instruction is latched; state becomes HELD (EMPTY for a NOP).
- Dispatch: when go is high at an edge:
  - The class strobe and the disp_* fields, with disp_tag = current counter, are registered and visible the next cycle.
  - The tag counter increments; it wraps from 2^TAG_WIDTH-1 to 0.
- Simultaneous dispatch and accept: a new instruction is accepted on the same edge the held one dispatches. State stays HELD, giving sustained throughput of 1 instruction per cycle.
- Dispatch without new input: state returns to EMPTY.
- Latency: accept at edge N, earliest dispatch strobe visible after edge N+1.
- Strobes:
  - Strobes last exactly one cycle.
  - alu_dispatch and lsu_dispatch are never high together.
  - disp_* fields hold their last value when no strobe is active.
- Flush:
  - Has priority over accept and dispatch in the same cycle.
  - Held instruction is dropped; state goes to EMPTY.
  - Strobes are 0 in the next cycle; tag counter loads flush_tag.
  - iq_stall is high during flush, so no instruction is accepted that cycle.
- Resource loss: if a resource drops while HELD, the instruction waits indefinitely. No timeout; the held value and tag are unchanged.
- Reset mid-stall or mid-dispatch: the held instruction is lost and the strobe is cleared immediately, asynchronously.

Test Plan:
1. Reset, then iq_valid=1, iq_instr=32'h8C430004 (lw) with all frees high -> lsu_dispatch pulses 2 cycles later; disp_tag=0, disp_rs=2, disp_rt=3, disp_imm=16'h0004; iq_stall stays 0.
2. Back-to-back stream of 20 ALU instructions (add) with all frees high -> one alu_dispatch per cycle; tags 0..15 then 0..3 (wrap); iq_stall never asserted.
3. Hold lsu_rs_free=0 with a sw held and an add offered -> iq_stall=1 and no strobes; raise lsu_rs_free -> sw dispatched first, add next cycle; order and tags preserved.
4. iq_instr=0 (NOP) between two adds -> only two alu_dispatch pulses, with consecutive tags 0 and 1.
5. flush=1, flush_tag=4'd9 while HELD and rob_free=1 -> no strobe next cycle, state EMPTY; next dispatched instruction carries tag 9.
6. Assert reset_n=0 mid-cycle while a strobe is high -> strobe and all outputs drop to 0 immediately; the first dispatch after release carries tag 0.
